// File: rtl/decode_latch.sv
// IF/ID boundary register with the taken-branch redirect sequencer for the 3-stage pipe.
// Squashes PENALTY wrong-path slots per branch and keeps a saturating bubble counter.
module decode_latch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned PENALTY   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [1:0]       redirect_cnt,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [1:0] PEN = 2'(PENALTY);

  state_t           state;
  logic [CNT_W-1:0] bubble_inc;

  always_comb begin
    bubble_inc = bubble_count;
    if (!(&bubble_count))
      bubble_inc = bubble_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      id_pc        <= '0;
      id_instr     <= NOP_INSTR;
      id_valid     <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      redirect_cnt <= '0;
      bubble_count <= '0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          id_pc <= if_pc;
          if (branch_taken) begin
            redirect     <= 1'b1;
            redirect_pc  <= branch_target;
            redirect_cnt <= PEN;
            id_instr     <= NOP_INSTR;
            id_valid     <= 1'b0;
            bubble_count <= bubble_inc;
            state        <= SQUASH;
          end else begin
            id_instr     <= if_instr;
            id_valid     <= 1'b1;
            redirect     <= 1'b0;
            redirect_cnt <= '0;
          end
        end
        SQUASH: begin
          // branch_taken is deliberately not looked at here: EX holds a bubble.
          redirect <= 1'b0;
          id_pc    <= if_pc;
          if (redirect_cnt > 2'd1) begin
            redirect_cnt <= redirect_cnt - 2'd1;
            id_instr     <= NOP_INSTR;
            id_valid     <= 1'b0;
            bubble_count <= bubble_inc;
          end else begin
            // Count of 0 can only occur with an illegal PENALTY; clamp instead of wrapping.
            redirect_cnt <= (redirect_cnt != 2'd0) ? redirect_cnt - 2'd1 : 2'd0;
            id_instr     <= if_instr;
            id_valid     <= 1'b1;
            state        <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_latch.sv
// Directed-vector bench for decode_latch: default instance (PENALTY=2, CNT_W=16)
// plus a PENALTY=3, CNT_W=4 instance for deeper squash and counter saturation.
module tb_decode_latch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] if_pc, if_instr, branch_target;
  logic [31:0] id_pc, id_instr, redirect_pc;
  logic        id_valid, redirect;
  logic [1:0]  redirect_cnt;
  logic [15:0] bubble_count;

  logic        reset2, taken2;
  logic [31:0] target2;
  logic [31:0] id_pc2, id_instr2, redirect_pc2;
  logic        id_valid2, redirect2;
  logic [1:0]  redirect_cnt2;
  logic [3:0]  bubble_count2;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  decode_latch #(.NOP_INSTR(NOP), .PENALTY(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_cnt(redirect_cnt), .bubble_count(bubble_count)
  );

  decode_latch #(.NOP_INSTR(NOP), .PENALTY(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset2), .if_pc(if_pc), .if_instr(if_instr), .stall(1'b0),
    .branch_taken(taken2), .branch_target(target2),
    .id_pc(id_pc2), .id_instr(id_instr2), .id_valid(id_valid2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .redirect_cnt(redirect_cnt2), .bubble_count(bubble_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic rd, input logic [31:0] rpc,
                         input logic [1:0] cnt, input logic vld, input logic [31:0] bub);
    chk({tag, ".redirect"},     32'(redirect),     32'(rd));
    chk({tag, ".redirect_pc"},  redirect_pc,       rpc);
    chk({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(cnt));
    chk({tag, ".id_valid"},     32'(id_valid),     32'(vld));
    chk({tag, ".bubble_count"}, 32'(bubble_count), bub);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".id_pc"},    id_pc,    32'h0);
    chk({tag, ".id_instr"}, id_instr, NOP);
    chk_ctl(tag, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] ins);
    if_pc    = pc;
    if_instr = ins;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h99;
    reset2 = 1'b0; taken2 = 1'b0; target2 = 32'hA0;
    feed(32'h123, 32'hDEAD_BEEF);

    // Reset dominates stall and branch_taken
    tick(); tick();
    chk_reset("reset");

    // Straight-line flow, one-cycle IF->ID latency
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    feed(32'h0, 32'hAAAA_0001); tick();
    chk("line0.id_pc", id_pc, 32'h0); chk("line0.id_instr", id_instr, 32'hAAAA_0001);
    chk_ctl("line0", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);
    feed(32'h4, 32'hBBBB_0002); tick();
    chk("line1.id_pc", id_pc, 32'h4); chk("line1.id_instr", id_instr, 32'hBBBB_0002);
    feed(32'h8, 32'hCCCC_0003); tick();
    chk("line2.id_pc", id_pc, 32'h8); chk("line2.id_instr", id_instr, 32'hCCCC_0003);
    chk("line2.id_valid", 32'(id_valid), 32'd1);

    // Taken branch to 0x40; branch_taken left high into SQUASH must be ignored
    branch_taken = 1'b1; branch_target = 32'h40; feed(32'hC, 32'hDDDD_0004); tick();
    chk("br_t1.id_instr", id_instr, NOP);
    chk_ctl("br_t1", 1'b1, 32'h40, 2'd2, 1'b0, 32'd1);
    branch_target = 32'h77; feed(32'h10, 32'hEEEE_0005); tick();
    chk("br_t2.id_instr", id_instr, NOP);
    chk_ctl("br_t2", 1'b0, 32'h40, 2'd1, 1'b0, 32'd2);

    // Stall three cycles mid-squash: everything frozen
    stall = 1'b1; branch_target = 32'h80; feed(32'h99, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.id_instr", id_instr, NOP);
      chk_ctl("stall", 1'b0, 32'h40, 2'd1, 1'b0, 32'd2);
    end

    // Resume: first target-path word reaches decode
    stall = 1'b0; branch_taken = 1'b0; feed(32'h40, 32'hF0F0_0006); tick();
    chk("br_t3.id_pc", id_pc, 32'h40); chk("br_t3.id_instr", id_instr, 32'hF0F0_0006);
    chk_ctl("br_t3", 1'b0, 32'h40, 2'd0, 1'b1, 32'd2);
    feed(32'h44, 32'h1234_5678); tick();
    chk("run.id_pc", id_pc, 32'h44); chk("run.id_instr", id_instr, 32'h1234_5678);
    chk_ctl("run", 1'b0, 32'h40, 2'd0, 1'b1, 32'd2);

    // Second branch, then reset in the middle of its squash
    branch_taken = 1'b1; branch_target = 32'h200; feed(32'h48, 32'h2222_2222); tick();
    chk_ctl("br2_t1", 1'b1, 32'h200, 2'd2, 1'b0, 32'd3);
    branch_target = 32'h300; tick();
    chk_ctl("br2_t2", 1'b0, 32'h200, 2'd1, 1'b0, 32'd4);
    reset = 1'b0; tick();
    chk_reset("midreset");

    // FSM back in RUN: a taken branch is accepted immediately
    reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h500; tick();
    chk_ctl("post_rst", 1'b1, 32'h500, 2'd2, 1'b0, 32'd1);
    branch_taken = 1'b0;

    // PENALTY=3 instance: 3,2,1,0 countdown, then saturation at 4'hF
    reset2 = 1'b1; taken2 = 1'b1; feed(32'h60, 32'h3333_3333); tick();
    chk("p3_t1.redirect", 32'(redirect2), 32'd1);
    chk("p3_t1.redirect_pc", redirect_pc2, 32'hA0);
    chk("p3_t1.cnt", 32'(redirect_cnt2), 32'd3);
    tick();
    chk("p3_t2.redirect", 32'(redirect2), 32'd0);
    chk("p3_t2.cnt", 32'(redirect_cnt2), 32'd2);
    chk("p3_t2.id_instr", id_instr2, NOP);
    tick();
    chk("p3_t3.cnt", 32'(redirect_cnt2), 32'd1);
    chk("p3_t3.bubbles", 32'(bubble_count2), 32'd3);
    feed(32'hA0, 32'h4444_4444); tick();
    chk("p3_t4.cnt", 32'(redirect_cnt2), 32'd0);
    chk("p3_t4.id_valid", 32'(id_valid2), 32'd1);
    chk("p3_t4.id_instr", id_instr2, 32'h4444_4444);
    chk("p3_t4.bubbles", 32'(bubble_count2), 32'd3);
    for (int i = 0; i < 76; i++) tick();
    chk("sat.bubbles", 32'(bubble_count2), 32'hF);
    taken2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
